alu_issue_unit: RTL and testbench

- Multicycle operand-fetch / write-back stage wrapped around the combinational ALU.
- Accepts one decoded instruction per handshake and reads Rsrc and Rdest from an internal 16x16 register file, or builds an extended immediate.
- Drives the ALU inputs and opcode, then captures the ALU result and flags.
- Writes the result back to the register file and updates the 5-bit processor status register (PSR).

---
 rtl/alu_issue_unit.sv | 172 +++++++++++++++++
 tb/tb_alu_issue_unit.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_unit.sv
// alu_issue_unit: operand-fetch / write-back wrapper around an external
// combinational ALU. Holds a 16x16 register file and the 5-bit PSR
// {N,Z,F,L,C}. One instruction moves through IDLE -> FETCH -> EXEC -> WB.
// Optional build macro ISSUE_FAST_EN: accept in WB as well, giving
// 3-cycle throughput, with a write-before-read bypass on the fetch.
module alu_issue_unit #(
    parameter int REGS  = 16,
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_instr_valid,
    output logic             o_instr_ready,
    input  logic [20:0]      i_instr,
    output logic [WIDTH-1:0] o_alu_rsrc,
    output logic [WIDTH-1:0] o_alu_rdest,
    output logic [4:0]       o_alu_opcode,
    output logic             o_alu_cin,
    input  logic [WIDTH-1:0] i_alu_out,
    input  logic [4:0]       i_alu_flags,
    output logic [4:0]       o_psr,
    output logic             o_wb_valid,
    output logic [3:0]       o_wb_addr,
    output logic [WIDTH-1:0] o_wb_data,
    output logic             o_illegal,
    input  logic [3:0]       i_dbg_addr,
    output logic [WIDTH-1:0] o_dbg_data
);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_WB} state_t;

    state_t                      r_state;
    logic [20:0]                 r_instr;
    logic [REGS-1:0][WIDTH-1:0]  r_regs;
    logic [WIDTH-1:0]            r_alu_rsrc;
    logic [WIDTH-1:0]            r_alu_rdest;
    logic [4:0]                  r_alu_opcode;
    logic [4:0]                  r_psr;
    logic                        r_wb_valid;
    logic [3:0]                  r_wb_addr;
    logic [WIDTH-1:0]            r_wb_data;
    logic                        r_illegal;

    logic [4:0]       w_op;
    logic [3:0]       w_rd_a;
    logic [3:0]       w_rs_a;
    logic [7:0]       w_imm8;
    logic [WIDTH-1:0] w_imm_ext;
    logic [WIDTH-1:0] w_rd_val;
    logic [WIDTH-1:0] w_rs_val;
    logic             w_accept;
    logic             w_is_cmp;
    logic             w_is_illegal;
    logic             w_sets_psr;

    // Opcodes whose Rsrc operand comes from imm8 rather than the register file.
    function automatic logic f_is_imm(input logic [4:0] op);
        case (op)
            5'b00001, 5'b00011, 5'b00110, 5'b00111, 5'b01001,
            5'b01011, 5'b01100, 5'b10010, 5'b10100: f_is_imm = 1'b1;
            default:                                f_is_imm = 1'b0;
        endcase
    endfunction

    // Unsigned immediates and shift counts are zero-extended; the rest sign-extend.
    function automatic logic f_zext(input logic [4:0] op);
        case (op)
            5'b00011, 5'b00110, 5'b01100, 5'b10010, 5'b10100: f_zext = 1'b1;
            default:                                          f_zext = 1'b0;
        endcase
    endfunction

    assign w_op   = r_instr[20:16];
    assign w_rd_a = r_instr[15:12];
    assign w_rs_a = r_instr[11:8];
    assign w_imm8 = r_instr[7:0];

    assign w_imm_ext = f_zext(w_op) ? {{(WIDTH-8){1'b0}}, w_imm8}
                                    : {{(WIDTH-8){w_imm8[7]}}, w_imm8};

    assign w_is_cmp     = (w_op == 5'b01010) || (w_op == 5'b01011) || (w_op == 5'b01100);
    assign w_is_illegal = (w_op > 5'b10110);
    assign w_sets_psr   = (w_op <= 5'b01100);

`ifdef ISSUE_FAST_EN
    // The previous result is forwarded while its write-back pulse is still up.
    assign w_rd_val = (r_wb_valid && r_wb_addr == w_rd_a) ? r_wb_data : r_regs[w_rd_a];
    assign w_rs_val = (r_wb_valid && r_wb_addr == w_rs_a) ? r_wb_data : r_regs[w_rs_a];
    assign o_instr_ready = (r_state == S_IDLE) || (r_state == S_WB);
`else
    assign w_rd_val = r_regs[w_rd_a];
    assign w_rs_val = r_regs[w_rs_a];
    assign o_instr_ready = (r_state == S_IDLE);
`endif

    assign w_accept = i_instr_valid && o_instr_ready;

    // Sequencer: latch instruction, fetch operands, settle, then commit.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_instr      <= '0;
            r_regs       <= '0;
            r_alu_rsrc   <= '0;
            r_alu_rdest  <= '0;
            r_alu_opcode <= '0;
            r_psr        <= '0;
            r_wb_valid   <= 1'b0;
            r_wb_addr    <= '0;
            r_wb_data    <= '0;
            r_illegal    <= 1'b0;
        end else begin
            r_wb_valid <= 1'b0;
            r_illegal  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_instr <= i_instr;
                        r_state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    r_alu_rdest  <= w_rd_val;
                    r_alu_rsrc   <= f_is_imm(w_op) ? w_imm_ext : w_rs_val;
                    r_alu_opcode <= w_op;
                    r_state      <= S_EXEC;
                end
                S_EXEC: begin
                    r_state <= S_WB;
                end
                S_WB: begin
                    if (w_is_illegal) begin
                        r_illegal <= 1'b1;
                    end else begin
                        if (!w_is_cmp) begin
                            r_regs[w_rd_a] <= i_alu_out;
                            r_wb_valid     <= 1'b1;
                            r_wb_addr      <= w_rd_a;
                            r_wb_data      <= i_alu_out;
                        end
                        if (w_sets_psr) begin
                            r_psr <= i_alu_flags;
                        end
                    end
`ifdef ISSUE_FAST_EN
                    if (w_accept) begin
                        r_instr <= i_instr;
                        r_state <= S_FETCH;
                    end else begin
                        r_state <= S_IDLE;
                    end
`else
                    r_state <= S_IDLE;
`endif
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_alu_rsrc   = r_alu_rsrc;
    assign o_alu_rdest  = r_alu_rdest;
    assign o_alu_opcode = r_alu_opcode;
    assign o_alu_cin    = r_psr[0];
    assign o_psr        = r_psr;
    assign o_wb_valid   = r_wb_valid;
    assign o_wb_addr    = r_wb_addr;
    assign o_wb_data    = r_wb_data;
    assign o_illegal    = r_illegal;
    assign o_dbg_data   = r_regs[i_dbg_addr];

endmodule

// File: tb/tb_alu_issue_unit.sv
// Bench for alu_issue_unit: a stand-in ALU, an architectural model that
// executes each instruction when it is accepted and releases its effects
// three edges later, a per-cycle compare, and hand-computed literal pins.
module tb_alu_issue_unit;

`ifdef ISSUE_FAST_EN
    localparam int FAST = 1;
`else
    localparam int FAST = 0;
`endif

    logic        clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_instr_valid = 1'b0;
    logic        o_instr_ready;
    logic [20:0] i_instr = '0;
    logic [15:0] o_alu_rsrc, o_alu_rdest;
    logic [4:0]  o_alu_opcode;
    logic        o_alu_cin;
    logic [15:0] i_alu_out;
    logic [4:0]  i_alu_flags;
    logic [4:0]  o_psr;
    logic        o_wb_valid;
    logic [3:0]  o_wb_addr;
    logic [15:0] o_wb_data;
    logic        o_illegal;
    logic [3:0]  i_dbg_addr = '0;
    logic [15:0] o_dbg_data;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;

    alu_issue_unit #(.REGS(16), .WIDTH(16)) dut (
        .i_clk(clk), .i_reset(i_reset),
        .i_instr_valid(i_instr_valid), .o_instr_ready(o_instr_ready), .i_instr(i_instr),
        .o_alu_rsrc(o_alu_rsrc), .o_alu_rdest(o_alu_rdest), .o_alu_opcode(o_alu_opcode),
        .o_alu_cin(o_alu_cin), .i_alu_out(i_alu_out), .i_alu_flags(i_alu_flags),
        .o_psr(o_psr), .o_wb_valid(o_wb_valid), .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data),
        .o_illegal(o_illegal), .i_dbg_addr(i_dbg_addr), .o_dbg_data(o_dbg_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in ALU; flags are {N,Z,F,L,C} with N/L as signed/unsigned Rdest<Rsrc.
    function automatic logic [20:0] alu_f(input logic [4:0] op, input logic [15:0] rd,
                                          input logic [15:0] rs, input logic cin);
        logic [16:0] s;
        logic [15:0] r;
        logic c, f;
        s = '0; r = '0; c = 1'b0; f = 1'b0;
        if (op <= 5'b00111) begin
            s = {1'b0, rd} + {1'b0, rs} + {16'b0, (op >= 5'b00100) & cin};
            r = s[15:0]; c = s[16];
            f = (rd[15] == rs[15]) && (r[15] != rd[15]);
        end else if (op <= 5'b01100) begin
            s = {1'b0, rd} - {1'b0, rs};
            r = s[15:0]; c = s[16];
            f = (rd[15] != rs[15]) && (r[15] != rd[15]);
        end else begin
            case (op)
                5'b01101: r = rd & rs;
                5'b01110: r = rd | rs;
                5'b01111: r = rd ^ rs;
                5'b10000: r = ~rs;
                5'b10001, 5'b10010: r = rd << rs[3:0];
                5'b10011, 5'b10100: r = rd >> rs[3:0];
                5'b10101: r = rs;
                5'b10110: r = {rs[7:0], 8'h00};
                default:  r = 16'hDEAD;
            endcase
        end
        return {($signed(rd) < $signed(rs)), (r == 16'h0), f, (rd < rs), c, r};
    endfunction

    assign {i_alu_flags, i_alu_out} = alu_f(o_alu_opcode, o_alu_rdest, o_alu_rsrc, o_alu_cin);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [20:0] mk(input logic [4:0] op, input logic [3:0] rd,
                                       input logic [3:0] rs, input logic [7:0] imm);
        return {op, rd, rs, imm};
    endfunction

    // ---------------- architectural model ----------------
    typedef struct {
        int          acc;
        logic [4:0]  op;
        logic [15:0] rd_v;
        logic [15:0] rs_v;
        logic        wr;
        logic [3:0]  a;
        logic [15:0] res;
        logic [4:0]  psr;
        logic        ill;
    } rec_t;

    rec_t        q[$];
    rec_t        rr;
    rec_t        nr;
    logic [15:0] m_reg [16];
    logic [15:0] v_reg [16];
    logic [4:0]  m_psr, v_psr;
    int          last_acc = -100;
    int          n_wb = 0;
    int          n_ill = 0;
    int          last_wb_cyc = -1;
    logic        ex_wb, ex_ill;
    logic [3:0]  ex_a;
    logic [15:0] ex_d;
    logic [20:0] fr;
    logic [4:0]  a_op;
    logic [7:0]  a_imm;
    logic        a_imm_op, a_zx;

    always @(negedge clk) begin
        if (i_reset) begin
            q.delete();
            for (int i = 0; i < 16; i++) begin m_reg[i] = '0; v_reg[i] = '0; end
            m_psr = '0; v_psr = '0; last_acc = -100;
            chk("rst_wb_valid", o_wb_valid, 0);
            chk("rst_illegal", o_illegal, 0);
            chk("rst_psr", o_psr, 0);
            chk("rst_ready", o_instr_ready, 1);
            chk("rst_alu_rsrc", o_alu_rsrc, 0);
            chk("rst_wb_data", o_wb_data, 0);
        end else begin
            ex_wb = 1'b0; ex_ill = 1'b0; ex_a = '0; ex_d = '0;
            if (q.size() > 0 && q[0].acc + 3 == cyc) begin
                rr = q.pop_front();
                if (rr.wr) begin v_reg[rr.a] = rr.res; ex_wb = 1'b1; end
                v_psr = rr.psr; ex_ill = rr.ill; ex_a = rr.a; ex_d = rr.res;
            end
            if (o_wb_valid) begin n_wb++; last_wb_cyc = cyc; end
            if (o_illegal) n_ill++;
            chk("wb_valid", o_wb_valid, ex_wb);
            chk("illegal", o_illegal, ex_ill);
            if (ex_wb) begin
                chk("wb_addr", o_wb_addr, ex_a);
                chk("wb_data", o_wb_data, ex_d);
            end
            chk("psr", o_psr, v_psr);
            chk("alu_cin", o_alu_cin, v_psr[0]);
            chk("instr_ready", o_instr_ready, (cyc >= last_acc + 3 - FAST));
            chk("dbg_data", o_dbg_data, v_reg[i_dbg_addr]);
            if (q.size() > 0 && (cyc == q[0].acc + 1 || cyc == q[0].acc + 2)) begin
                chk("alu_opcode", o_alu_opcode, q[0].op);
                chk("alu_rdest", o_alu_rdest, q[0].rd_v);
                chk("alu_rsrc", o_alu_rsrc, q[0].rs_v);
            end
            // Acceptance at the coming edge: execute architecturally now.
            if (i_instr_valid && o_instr_ready) begin
                a_op  = i_instr[20:16];
                a_imm = i_instr[7:0];
                a_imm_op = (a_op inside {5'b00001, 5'b00011, 5'b00110, 5'b00111, 5'b01001,
                                         5'b01011, 5'b01100, 5'b10010, 5'b10100});
                a_zx  = (a_op inside {5'b00011, 5'b00110, 5'b01100, 5'b10010, 5'b10100});
                nr.acc  = cyc + 1;
                nr.op   = a_op;
                nr.a    = i_instr[15:12];
                nr.rd_v = m_reg[i_instr[15:12]];
                nr.rs_v = !a_imm_op ? m_reg[i_instr[11:8]]
                        : (a_zx ? {8'h00, a_imm} : {{8{a_imm[7]}}, a_imm});
                fr      = alu_f(a_op, nr.rd_v, nr.rs_v, m_psr[0]);
                nr.res  = fr[15:0];
                nr.ill  = (a_op > 5'b10110);
                nr.wr   = !nr.ill && !(a_op inside {5'b01010, 5'b01011, 5'b01100});
                if (!nr.ill && a_op <= 5'b01100) m_psr = fr[20:16];
                if (nr.wr) m_reg[nr.a] = nr.res;
                nr.psr  = m_psr;
                q.push_back(nr);
                last_acc = cyc + 1;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic issue(input logic [20:0] ins, input bit keep, output int acc);
        bit got;
        got = 1'b0; acc = -1;
        i_instr = ins; i_instr_valid = 1'b1;
        for (int t = 0; t < 40 && !got; t++) begin
            @(negedge clk);
            if (o_instr_ready) begin
                @(posedge clk); #1;
                acc = cyc; got = 1'b1;
            end
        end
        if (!got) begin
            n_cmp++; n_fail++;
            $display("FAIL accept_timeout: got no acceptance expected one within 40 cycles");
        end
        if (!keep) i_instr_valid = 1'b0;
    endtask

    task automatic settle();
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic chk_reg(input string nm, input logic [3:0] a, input logic [15:0] exp);
        i_dbg_addr = a;
        #1;
        chk(nm, o_dbg_data, exp);
    endtask

    int a0, a1, a2, wb0;

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200us");
        n_fail++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 i_reset = 1'b0;

        // Reset during EXEC of ADDI r1,#5 aborts it.
        wb0 = n_wb;
        issue(mk(5'b00001, 4'd1, 4'd0, 8'd5), 1'b0, a0);
        @(posedge clk); #1;
        i_reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 i_reset = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", o_instr_ready, 1);
        settle();
        chk("abort_no_wb", n_wb - wb0, 0);
        chk_reg("abort_r1", 4'd1, 16'h0000);
        chk("abort_psr", o_psr, 5'b00000);

        // ADDI / ADD chain.
        issue(mk(5'b00001, 4'd1, 4'd0, 8'd5), 1'b0, a0);
        settle();
        chk("latency_wb", last_wb_cyc - a0, 3);
        chk_reg("addi_r1", 4'd1, 16'h0005);
        chk("addi_psr", o_psr, 5'b10010);
        issue(mk(5'b00001, 4'd2, 4'd0, 8'hFD), 1'b0, a0);
        settle();
        chk_reg("addi_r2_sext", 4'd2, 16'hFFFD);
        issue(mk(5'b00000, 4'd3, 4'd2, 8'h00), 1'b0, a0);
        issue(mk(5'b00000, 4'd3, 4'd1, 8'h00), 1'b0, a0);
        settle();
        chk_reg("add_r3", 4'd3, 16'h0002);
        chk("add_psr", o_psr, 5'b10001);

        // Compare: no write, psr takes flags.
        wb0 = n_wb;
        issue(mk(5'b01010, 4'd1, 4'd2, 8'h00), 1'b0, a0);
        settle();
        chk("cmp_no_wb", n_wb - wb0, 0);
        chk_reg("cmp_r1", 4'd1, 16'h0005);
        chk("cmp_psr", o_psr, 5'b00011);

        // Carry-in from psr.C.
        issue(mk(5'b00111, 4'd7, 4'd0, 8'h00), 1'b0, a0);
        settle();
        chk_reg("addci_r7", 4'd7, 16'h0001);

        // Zero-extended immediate.
        issue(mk(5'b00011, 4'd4, 4'd0, 8'hFF), 1'b0, a0);
        @(negedge clk);
        @(negedge clk);
        chk("addui_alu_rsrc", o_alu_rsrc, 16'h00FF);
        settle();
        chk_reg("addui_r4", 4'd4, 16'h00FF);
        chk("addui_psr", o_psr, 5'b10010);

        // Logic op keeps psr, then illegal opcode.
        issue(mk(5'b01101, 4'd2, 4'd4, 8'h00), 1'b0, a0);
        settle();
        chk_reg("and_r2", 4'd2, 16'h00FD);
        chk("and_psr_kept", o_psr, 5'b10010);
        wb0 = n_wb;
        a1 = n_ill;
        issue(mk(5'b11000, 4'd2, 4'd1, 8'h00), 1'b0, a0);
        settle();
        chk("illegal_pulses", n_ill - a1, 1);
        chk("illegal_no_wb", n_wb - wb0, 0);
        chk_reg("illegal_r2", 4'd2, 16'h00FD);
        chk("illegal_psr", o_psr, 5'b10010);

        // rdest == rsrc reads the same pre-write value.
        issue(mk(5'b00000, 4'd4, 4'd4, 8'h00), 1'b0, a0);
        settle();
        chk_reg("add_self_r4", 4'd4, 16'h01FE);

        // Back-to-back dependent stream with valid held high.
        issue(mk(5'b00001, 4'd5, 4'd0, 8'd1), 1'b1, a0);
        issue(mk(5'b00001, 4'd5, 4'd0, 8'd2), 1'b1, a1);
        issue(mk(5'b00000, 4'd6, 4'd5, 8'h00), 1'b0, a2);
        settle();
        chk("stream_gap1", a1 - a0, 4 - FAST);
        chk("stream_gap2", a2 - a1, 4 - FAST);
        chk_reg("stream_r5", 4'd5, 16'h0003);
        chk_reg("stream_r6", 4'd6, 16'h0003);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
